// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline fetch/data ports plus RAM port of the shared-memory arbiter
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic [DATA_W-1:0] ifData;
  logic              ifValid;
  logic              flush;
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  logic              memDone;
  logic              memStall;
  logic              pcWrite;
  logic              ifIdWrite;
  logic              ramEn;
  logic              ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWdata;
  logic [DATA_W-1:0] ramRdata;
  logic              ramReady;
  modport slave (
    input  ifReq, ifAddr, flush, memRead, memWrite, memAddr, memWdata, ramRdata, ramReady,
    output ifData, ifValid, memRdata, memDone, memStall, pcWrite, ifIdWrite,
           ramEn, ramWe, ramAddr, ramWdata
  );
  modport master (
    output ifReq, ifAddr, flush, memRead, memWrite, memAddr, memWdata, ramRdata, ramReady,
    input  ifData, ifValid, memRdata, memDone, memStall, pcWrite, ifIdWrite,
           ramEn, ramWe, ramAddr, ramWdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between IF and MEM, buffers one instruction, drives stalls
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH_WAIT, DATA_WAIT} arbState;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  arbState state, nextState;
  logic [3:0] streak;
  logic discard, ramEnR, ramWeR, ifValidR, memDoneR;
  logic [ADDR_W-1:0] ramAddrR;
  logic [DATA_W-1:0] ramWdataR, ifDataR, memRdataR;
  logic dataElig, fetchElig, grantData, grantFetch, dataDone, fetchDone, pcWriteC;
  always_comb begin
    dataElig   = (bus.memRead | bus.memWrite) & ~memDoneR;
    fetchElig  = bus.ifReq & ~ifValidR & ~bus.flush;
    grantData  = (state == IDLE) & dataElig & ~(fetchElig & (streak == LIMIT));
    grantFetch = (state == IDLE) & fetchElig & ~grantData;
    dataDone   = (state == DATA_WAIT) & bus.ramReady;
    fetchDone  = (state == FETCH_WAIT) & bus.ramReady;
    pcWriteC   = ifValidR & ~dataElig & ~bus.flush;
    nextState  = grantData ? DATA_WAIT : grantFetch ? FETCH_WAIT :
                 (dataDone | fetchDone) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nextState;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramEnR    <= 1'b0;
      ramWeR    <= 1'b0;
      ramAddrR  <= '0;
      ramWdataR <= '0;
      ifDataR   <= '0;
      memRdataR <= '0;
      ifValidR  <= 1'b0;
      memDoneR  <= 1'b0;
      discard   <= 1'b0;
      streak    <= '0;
    end else begin
      ramEnR    <= (grantData | grantFetch) ? 1'b1 : (dataDone | fetchDone) ? 1'b0 : ramEnR;
      ramWeR    <= (grantData | grantFetch) ? (grantData & bus.memWrite) : ramWeR;
      ramAddrR  <= grantData ? bus.memAddr : grantFetch ? bus.ifAddr : ramAddrR;
      ramWdataR <= grantData ? bus.memWdata : ramWdataR;
      memDoneR  <= dataDone;
      memRdataR <= (dataDone & ~ramWeR) ? bus.ramRdata : memRdataR;
      ifDataR   <= fetchDone ? bus.ramRdata : ifDataR;
      // flush beats a same-edge completion, so the dropped instruction never shows as valid
      ifValidR  <= bus.flush ? 1'b0 : (fetchDone & ~discard) ? 1'b1 : pcWriteC ? 1'b0 : ifValidR;
      discard   <= fetchDone ? 1'b0 : ((state == FETCH_WAIT) & bus.flush) ? 1'b1 : discard;
      streak    <= grantFetch ? 4'd0 :
                   (grantData & fetchElig & (streak < LIMIT)) ? streak + 4'd1 : streak;
    end
  end
  assign bus.ramEn     = ramEnR;
  assign bus.ramWe     = ramWeR;
  assign bus.ramAddr   = ramAddrR;
  assign bus.ramWdata  = ramWdataR;
  assign bus.ifData    = ifDataR;
  assign bus.ifValid   = ifValidR;
  assign bus.memRdata  = memRdataR;
  assign bus.memDone   = memDoneR;
  assign bus.memStall  = dataElig;
  assign bus.pcWrite   = pcWriteC;
  assign bus.ifIdWrite = pcWriteC;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tasks for the shared RAM port arbiter (STARVE_LIMIT=2)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.ifReq = 0; bus.ifAddr = 0; bus.flush = 0; bus.memRead = 1; bus.memWrite = 0;
    bus.memAddr = 0; bus.memWdata = 0; bus.ramRdata = 0; bus.ramReady = 0;
    cyc(); cyc();
    checks++; if ({bus.ramEn, bus.ramWe, bus.ifValid, bus.memDone, bus.pcWrite, bus.ifIdWrite} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {bus.ramEn, bus.ramWe, bus.ifValid, bus.memDone, bus.pcWrite, bus.ifIdWrite}); end
    checks++; if ({bus.ramAddr, bus.ramWdata, bus.ifData, bus.memRdata} !== 128'h0) begin failures++; $display("FAIL reset_regs got=%h exp=0", {bus.ramAddr, bus.ramWdata, bus.ifData, bus.memRdata}); end
    checks++; if (bus.memStall !== 1'b1) begin failures++; $display("FAIL reset_memStall_hi got=%b exp=1", bus.memStall); end
    bus.memRead = 0;
    #1;
    checks++; if (bus.memStall !== 1'b0) begin failures++; $display("FAIL reset_memStall_lo got=%b exp=0", bus.memStall); end
    reset = 1'b0;
    cyc();
  endtask
  task automatic test_fetch();
    bus.ifReq = 1; bus.ifAddr = 32'h40; bus.ramReady = 1; bus.ramRdata = 32'h8C220004;
    cyc();
    checks++; if ({bus.ramEn, bus.ramWe, bus.ramAddr} !== {2'b10, 32'h40}) begin failures++; $display("FAIL fetch_grant got=%b/%b/%h exp=1/0/40", bus.ramEn, bus.ramWe, bus.ramAddr); end
    cyc();
    checks++; if ({bus.ifValid, bus.pcWrite, bus.ifIdWrite, bus.ramEn} !== 4'b1110) begin failures++; $display("FAIL fetch_done got=%b exp=1110", {bus.ifValid, bus.pcWrite, bus.ifIdWrite, bus.ramEn}); end
    checks++; if (bus.ifData !== 32'h8C220004) begin failures++; $display("FAIL fetch_ifData got=%h exp=8c220004", bus.ifData); end
    bus.ifReq = 0;
    cyc();
    checks++; if ({bus.ifValid, bus.ramEn} !== 2'b00) begin failures++; $display("FAIL fetch_consume got=%b exp=00", {bus.ifValid, bus.ramEn}); end
  endtask
  task automatic test_load();
    bus.memRead = 1; bus.memAddr = 32'h100; bus.ramReady = 0; bus.ramRdata = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) bus.ramReady = 1;
      #1;
      checks++; if ({bus.memStall, bus.memDone, bus.ramWe, bus.ramEn} !== {3'b100, logic'(c != 0)}) begin failures++; $display("FAIL load_wait%0d got=%b exp=100%0d", c, {bus.memStall, bus.memDone, bus.ramWe, bus.ramEn}, c != 0); end
      if (c != 0) begin
        checks++; if (bus.ramAddr !== 32'h100) begin failures++; $display("FAIL load_addr%0d got=%h exp=100", c, bus.ramAddr); end
      end
      cyc();
    end
    checks++; if ({bus.memDone, bus.memStall, bus.ramEn} !== 3'b100) begin failures++; $display("FAIL load_done got=%b exp=100", {bus.memDone, bus.memStall, bus.ramEn}); end
    checks++; if (bus.memRdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", bus.memRdata); end
    bus.memRead = 0;
    cyc();
    checks++; if (bus.memDone !== 1'b0) begin failures++; $display("FAIL load_pulse got=%b exp=0", bus.memDone); end
  endtask
  task automatic test_store_vs_fetch();
    bus.memWrite = 1; bus.memAddr = 32'h104; bus.memWdata = 32'h12345678;
    bus.ifReq = 1; bus.ifAddr = 32'h44; bus.ramReady = 1; bus.ramRdata = 32'h0BADF00D;
    cyc();
    checks++; if ({bus.ramEn, bus.ramWe, bus.ramAddr, bus.ramWdata} !== {2'b11, 32'h104, 32'h12345678}) begin failures++; $display("FAIL store_grant got=%b/%b/%h/%h exp=1/1/104/12345678", bus.ramEn, bus.ramWe, bus.ramAddr, bus.ramWdata); end
    cyc();
    checks++; if ({bus.memDone, bus.ramEn} !== 2'b10) begin failures++; $display("FAIL store_done got=%b exp=10", {bus.memDone, bus.ramEn}); end
    checks++; if (bus.memRdata !== 32'hDEADBEEF) begin failures++; $display("FAIL store_rdata_kept got=%h exp=deadbeef", bus.memRdata); end
    bus.memWrite = 0;
    cyc();
    checks++; if ({bus.ramEn, bus.ramWe, bus.ramAddr} !== {2'b10, 32'h44}) begin failures++; $display("FAIL store_then_fetch got=%b/%b/%h exp=1/0/44", bus.ramEn, bus.ramWe, bus.ramAddr); end
    cyc();
    checks++; if ({bus.ifValid, bus.ifData, bus.memRdata} !== {1'b1, 32'h0BADF00D, 32'hDEADBEEF}) begin failures++; $display("FAIL store_fetch_done got=%b/%h/%h exp=1/0badf00d/deadbeef", bus.ifValid, bus.ifData, bus.memRdata); end
    bus.ifReq = 0;
    cyc();
  endtask
  task automatic test_flush();
    bus.ifReq = 1; bus.ifAddr = 32'h80; bus.ramReady = 0; bus.ramRdata = 32'h11111111;
    cyc();
    checks++; if ({bus.ramEn, bus.ramAddr} !== {1'b1, 32'h80}) begin failures++; $display("FAIL flush_grant got=%b/%h exp=1/80", bus.ramEn, bus.ramAddr); end
    bus.flush = 1;
    cyc();
    bus.flush = 0; bus.ifAddr = 32'hC0; bus.ramReady = 1;
    checks++; if ({bus.ramEn, bus.ramAddr, bus.ifValid} !== {1'b1, 32'h80, 1'b0}) begin failures++; $display("FAIL flush_hold got=%b/%h/%b exp=1/80/0", bus.ramEn, bus.ramAddr, bus.ifValid); end
    cyc();
    checks++; if ({bus.ifValid, bus.ramEn} !== 2'b00) begin failures++; $display("FAIL flush_discard got=%b exp=00", {bus.ifValid, bus.ramEn}); end
    bus.ramRdata = 32'h22222222;
    cyc();
    checks++; if ({bus.ramEn, bus.ramAddr} !== {1'b1, 32'hC0}) begin failures++; $display("FAIL flush_refetch got=%b/%h exp=1/c0", bus.ramEn, bus.ramAddr); end
    cyc();
    checks++; if ({bus.ifValid, bus.ifData} !== {1'b1, 32'h22222222}) begin failures++; $display("FAIL flush_refetch_done got=%b/%h exp=1/22222222", bus.ifValid, bus.ifData); end
    bus.ifReq = 0; bus.memRead = 1; bus.memAddr = 32'h108; bus.ramReady = 0; bus.flush = 1;
    #1;
    checks++; if ({bus.memStall, bus.pcWrite, bus.ifIdWrite} !== 3'b100) begin failures++; $display("FAIL flush_stall_comb got=%b exp=100", {bus.memStall, bus.pcWrite, bus.ifIdWrite}); end
    cyc();
    bus.flush = 0;
    checks++; if ({bus.ifValid, bus.ramEn, bus.ramAddr} !== {2'b01, 32'h108}) begin failures++; $display("FAIL flush_stall_edge got=%b/%b/%h exp=0/1/108", bus.ifValid, bus.ramEn, bus.ramAddr); end
  endtask
  task automatic test_reset_in_wait();
    bus.memRead = 0;
    reset = 1'b1;
    #1;
    checks++; if ({bus.ramEn, bus.memDone} !== 2'b00) begin failures++; $display("FAIL rstwait_async got=%b exp=00", {bus.ramEn, bus.memDone}); end
    bus.ramReady = 1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    checks++; if ({bus.ramEn, bus.memDone} !== 2'b00) begin failures++; $display("FAIL rstwait_release got=%b exp=00", {bus.ramEn, bus.memDone}); end
    bus.memRead = 1; bus.memAddr = 32'h10C;
    cyc();
    checks++; if ({bus.ramEn, bus.ramAddr, bus.memDone} !== {1'b1, 32'h10C, 1'b0}) begin failures++; $display("FAIL rstwait_idle_grant got=%b/%h/%b exp=1/10c/0", bus.ramEn, bus.ramAddr, bus.memDone); end
    cyc();
    checks++; if (bus.memDone !== 1'b1) begin failures++; $display("FAIL rstwait_next_done got=%b exp=1", bus.memDone); end
    bus.memRead = 0;
    cyc();
  endtask
  task automatic test_starvation();
    string got = "";
    logic prevEn = bus.ramEn;
    bus.memAddr = 32'h100; bus.ifAddr = 32'h40; bus.ramReady = 1; bus.memRead = 1; bus.ifReq = 1;
    for (int c = 0; c < 60 && got.len() < 6; c++) begin
      cyc();
      if (bus.ramEn && !prevEn) got = {got, (bus.ramAddr == 32'h100) ? "D" : "F"};
      prevEn = bus.ramEn;
      bus.memRead = ~bus.ifValid;
      bus.ifReq = ~bus.memDone;
    end
    checks++; if (got != "DDFDDF") begin failures++; $display("FAIL starve_order got=%s exp=DDFDDF", got); end
    bus.memRead = 0; bus.ifReq = 0;
    cyc();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store_vs_fetch();
    test_flush();
    test_reset_in_wait();
    test_starvation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
